// File: rtl/cv32e40p_x_pkg.sv
// Shared types and defaults for the X-interface writeback path.
// x_result_t is one X result on its way to the register file: the
// destination register plus the data to write there.
package cv32e40p_x_pkg;

  localparam int unsigned X_DATA_WIDTH            = 32;
  localparam int unsigned X_WB_FIFO_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [4:0]              waddr;
    logic [X_DATA_WIDTH-1:0] wdata;
  } x_result_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Small synchronous FIFO of X results.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i  write one entry (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   data_o         current head entry
//   full_o/empty_o occupancy flags
// Pointers wrap at DEPTH so the depth does not need to be a power of two;
// full/empty come from an occupancy counter rather than pointer compares.
module cv32e40p_x_result_fifo
  import cv32e40p_x_pkg::*;
#(
  parameter int unsigned DEPTH = X_WB_FIFO_DEPTH_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  x_result_t data_i,
  input  logic      pop_i,
  output x_result_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned       PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W     = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  x_result_t        mem_q [DEPTH];
  x_result_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40p_x_wb_arb.sv
// Arbitrates the single register-file write port between the core WB stage
// and X-interface results, buffering X results that lose arbitration.
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   core_we_i/waddr/wdata      core WB write request
//   core_gnt_o                 core write accepted (low = core stalls WB)
//   x_rvalid_i/x_rready_o      X result handshake; x_rwaddr_i/x_rdata_i payload
//   rf_we_o/rf_waddr_o/rf_wdata_o register-file write port
//   x_done_o/x_done_addr_o     an X result retired, and its register
//   x_pending_o                buffered X results exist
// The core normally wins, but a buffered result that has lost STARVE_LIMIT
// cycles in a row takes the port for one cycle.
module cv32e40p_x_wb_arb
  import cv32e40p_x_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = X_WB_FIFO_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned DATA_WIDTH   = X_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_we_i,
  input  logic [4:0]            core_waddr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_gnt_o,
  input  logic                  x_rvalid_i,
  output logic                  x_rready_o,
  input  logic [4:0]            x_rwaddr_i,
  input  logic [DATA_WIDTH-1:0] x_rdata_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  x_done_o,
  output logic [4:0]            x_done_addr_o,
  output logic                  x_pending_o
);

  localparam int unsigned      SC_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]  SC_LIMIT  = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  x_result_t             in_res, head_res;
  logic                  fifo_full, fifo_empty;
  logic                  starve;
  logic                  core_win, head_win, bypass;
  logic                  push;
  logic [4:0]            win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  assign in_res.waddr = x_rwaddr_i;
  assign in_res.wdata = x_rdata_i;

  cv32e40p_x_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (in_res),
    .pop_i   (head_win),
    .data_o  (head_res),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign starve = rst_ni && !fifo_empty && (starve_cnt_q == SC_LIMIT);

  // Fixed-priority winner selection; everything is held off while in reset
  // so nothing reaches the register file or the scoreboard then.
  always_comb begin
    core_win = 1'b0;
    head_win = 1'b0;
    bypass   = 1'b0;
    if (!rst_ni) begin
      core_win = 1'b0;
    end else if (starve) begin
      head_win = 1'b1;
    end else if (core_we_i) begin
      core_win = 1'b1;
    end else if (!fifo_empty) begin
      head_win = 1'b1;
    end else if (x_rvalid_i) begin
      bypass = 1'b1;
    end
  end

  // A full FIFO refuses the beat even if its head pops this cycle.
  assign x_rready_o  = !fifo_full || !rst_ni;
  assign push        = rst_ni && x_rvalid_i && !fifo_full && !bypass;
  assign core_gnt_o  = rst_ni && !starve;
  assign x_pending_o = rst_ni && !fifo_empty;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    if (core_win) begin
      win_addr = core_waddr_i;
      win_data = core_wdata_i;
    end else if (head_win) begin
      win_addr = head_res.waddr;
      win_data = head_res.wdata;
    end else if (bypass) begin
      win_addr = x_rwaddr_i;
      win_data = x_rdata_i;
    end
  end

  // x0 writes are suppressed at the port but still retire on x_done_o so
  // the dispatcher scoreboard bit is cleared.
  assign rf_we_o       = (core_win || head_win || bypass) && (win_addr != 5'd0);
  assign rf_waddr_o    = win_addr;
  assign rf_wdata_o    = win_data;
  assign x_done_o      = head_win || bypass;
  assign x_done_addr_o = x_done_o ? win_addr : 5'd0;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || head_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // The dispatcher never lets core and an incoming X result target the
  // same (non-x0) register in one cycle.
  a_no_same_rd : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(core_we_i && x_rvalid_i && x_rready_o &&
      (core_waddr_i == x_rwaddr_i) && (core_waddr_i != 5'd0)));

endmodule

// File: tb/tb_cv32e40p_x_wb_arb.sv
// Directed bench for cv32e40p_x_wb_arb. Each accepted X beat is queued as an
// expected retirement; each x_done_o pulse pops the queue and checks the
// retired register and the register-file write it produced.
module tb_cv32e40p_x_wb_arb;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } expRes_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        coreWe;
  logic [4:0]  coreAddr;
  logic [31:0] coreData;
  logic        coreGnt;
  logic        xValid;
  logic        xReady;
  logic [4:0]  xAddr;
  logic [31:0] xData;
  logic        rfWe;
  logic [4:0]  rfAddr;
  logic [31:0] rfData;
  logic        xDone;
  logic [4:0]  xDoneAddr;
  logic        xPending;

  int          vectors = 0;
  int          miscompares = 0;
  expRes_t     expQ[$];

  cv32e40p_x_wb_arb #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (3),
    .DATA_WIDTH   (32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .core_we_i     (coreWe),
    .core_waddr_i  (coreAddr),
    .core_wdata_i  (coreData),
    .core_gnt_o    (coreGnt),
    .x_rvalid_i    (xValid),
    .x_rready_o    (xReady),
    .x_rwaddr_i    (xAddr),
    .x_rdata_i     (xData),
    .rf_we_o       (rfWe),
    .rf_waddr_o    (rfAddr),
    .rf_wdata_o    (rfData),
    .x_done_o      (xDone),
    .x_done_addr_o (xDoneAddr),
    .x_pending_o   (xPending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Accepted beats are queued before retirements are popped so a bypass
  // (accept and retire in one cycle) matches its own entry.
  task automatic scoreboardCycle();
    expRes_t e;
    if (xValid && xReady) begin
      e.addr = xAddr;
      e.data = xData;
      expQ.push_back(e);
    end
    if (xDone) begin
      checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("sb_done_addr", 32'(xDoneAddr), 32'(e.addr));
        checkOutput("sb_rf_we", 32'(rfWe), 32'(e.addr != 5'd0));
        if (e.addr != 5'd0) begin
          checkOutput("sb_rf_addr", 32'(rfAddr), 32'(e.addr));
          checkOutput("sb_rf_data", rfData, e.data);
        end
      end
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then sample on
  // the falling edge where the combinational outputs have settled.
  task automatic applyStimulus(input logic cWe, input logic [4:0] cAddr,
                               input logic [31:0] cData, input logic xV,
                               input logic [4:0] xA, input logic [31:0] xD);
    @(posedge clk);
    #1;
    coreWe   = cWe;
    coreAddr = cAddr;
    coreData = cData;
    xValid   = xV;
    xAddr    = xA;
    xData    = xD;
    @(negedge clk);
    scoreboardCycle();
  endtask

  initial begin
    rstN     = 1'b0;
    coreWe   = 1'b0;
    coreAddr = '0;
    coreData = '0;
    xValid   = 1'b0;
    xAddr    = '0;
    xData    = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rready", 32'(xReady), 32'd1);
    checkOutput("rst_gnt", 32'(coreGnt), 32'd0);
    checkOutput("rst_rf_we", 32'(rfWe), 32'd0);
    checkOutput("rst_done", 32'(xDone), 32'd0);
    checkOutput("rst_pending", 32'(xPending), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Bypass with an idle core and empty FIFO.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAA);
    checkOutput("byp_rf_we", 32'(rfWe), 32'd1);
    checkOutput("byp_rf_addr", 32'(rfAddr), 32'd5);
    checkOutput("byp_rf_data", rfData, 32'hAA);
    checkOutput("byp_done", 32'(xDone), 32'd1);
    checkOutput("byp_gnt", 32'(coreGnt), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("byp_pending", 32'(xPending), 32'd0);
    checkOutput("idle_rf_we", 32'(rfWe), 32'd0);
    checkOutput("idle_done", 32'(xDone), 32'd0);

    // Core holds the port; X 6 and 7 buffer, 8 is refused while full.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd6, 32'h66);
    checkOutput("buf_gnt0", 32'(coreGnt), 32'd1);
    checkOutput("buf_rf_addr0", 32'(rfAddr), 32'd1);
    checkOutput("buf_done0", 32'(xDone), 32'd0);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 32'h77);
    checkOutput("buf_pending", 32'(xPending), 32'd1);
    checkOutput("buf_rready1", 32'(xReady), 32'd1);
    checkOutput("buf_gnt1", 32'(coreGnt), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88);
    checkOutput("full_rready2", 32'(xReady), 32'd0);
    checkOutput("full_gnt2", 32'(coreGnt), 32'd1);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88);
    checkOutput("full_rready3", 32'(xReady), 32'd0);
    checkOutput("full_gnt3", 32'(coreGnt), 32'd1);
    // Fourth cycle after 6 was pushed: starvation hands 6 the port.
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88);
    checkOutput("starve_gnt", 32'(coreGnt), 32'd0);
    checkOutput("starve_rf_addr", 32'(rfAddr), 32'd6);
    checkOutput("starve_rready", 32'(xReady), 32'd0);
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88);
    checkOutput("regain_gnt", 32'(coreGnt), 32'd1);
    checkOutput("regain_rf_addr", 32'(rfAddr), 32'd4);
    checkOutput("regain_rready", 32'(xReady), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("drain_rf_addr7", 32'(rfAddr), 32'd7);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("drain_rf_addr8", 32'(rfAddr), 32'd8);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("drain_pending", 32'(xPending), 32'd0);

    // Core 3 alongside X 9: core writes, 9 buffers, then 10 queues behind 9.
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    checkOutput("same_rf_addr", 32'(rfAddr), 32'd3);
    checkOutput("same_done", 32'(xDone), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0);
    checkOutput("order_rf_addr9", 32'(rfAddr), 32'd9);
    checkOutput("order_pending", 32'(xPending), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("order_rf_addr10", 32'(rfAddr), 32'd10);

    // x0 result: no register write, but it still retires.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    checkOutput("x0_rf_we", 32'(rfWe), 32'd0);
    checkOutput("x0_done", 32'(xDone), 32'd1);
    checkOutput("x0_done_addr", 32'(xDoneAddr), 32'd0);

    // Fill the FIFO, then reset: buffered results are discarded.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC0);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd13, 32'hD0);
    checkOutput("prerst_pending", 32'(xPending), 32'd1);
    @(posedge clk);
    #1;
    rstN   = 1'b0;
    coreWe = 1'b0;
    xValid = 1'b0;
    @(negedge clk);
    checkOutput("inrst_rf_we", 32'(rfWe), 32'd0);
    checkOutput("inrst_done", 32'(xDone), 32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    scoreboardCycle();
    checkOutput("postrst_pending", 32'(xPending), 32'd0);
    checkOutput("postrst_rready", 32'(xReady), 32'd1);
    checkOutput("postrst_rf_we", 32'(rfWe), 32'd0);
    checkOutput("postrst_done", 32'(xDone), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("postrst_done2", 32'(xDone), 32'd0);

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
